// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX arbiter, the TX datapath and the
// RX path. Holds the arbiter state encoding, the default byte width and
// the clock/baud constants that every UART block derives its timing from.
package uart_pkg;

  // Default byte width used on requester ports and on the TX data path.
  localparam int DEFAULT_DATA_W = 8;

  // System clock and line rate shared by the RX and TX bit-timing logic.
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUDRATE = 115_200;
  localparam int BAUD_DIV = CLK_FREQ / BAUDRATE;

  // Arbiter FSM states.
  //   IDLE      : no owner, searching the request vector
  //   ISSUE     : one-cycle tx_start / ack handshake
  //   WAIT_BUSY : transmitter has been started, waiting for tx_busy to rise
  //   WAIT_DONE : frame on the line, waiting for tx_busy to fall
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
// Returns the index of the first set bit of req at or after rr_ptr,
// wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDX_W    highest-priority position for this search
//   idx     out IDX_W    selected requester (0 when none found)
//   found   out 1        at least one request bit is set
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  // NOTE: every signal written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte transmitter among NUM_REQ requesters.
// Round-robin between packets; once a requester owns the transmitter it keeps
// it until a byte flagged req_last has gone out (or it drops req), so a
// multi-byte message is never interleaved with another requester's bytes.
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset (shared with the TX datapath)
//   req          in   per-requester level request, held until ack
//   req_data     in   requester i byte at [i*DATA_W +: DATA_W]
//   req_last     in   byte ends the requester's packet
//   ack          out  one-cycle pulse to the owner when its byte is accepted
//   grant_id     out  current / last owner
//   grant_valid  out  an owner holds the transmitter
//   tx_start     out  one-cycle pulse: transmitter loads tx_data
//   tx_data      out  byte being sent, stable until tx_busy falls
//   tx_busy      in   transmitter is shifting a frame
//   err_timeout  out  one-cycle pulse: tx_busy never rose after tx_start
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = DEFAULT_DATA_W,
  parameter  int BUSY_TIMEOUT = 64,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      grant_valid,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      err_timeout
);

  localparam logic [7:0]       TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

  uart_arb_state_t state, state_nxt;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [7:0]        busy_cnt;
  logic              last_q;       // req_last of the byte currently in flight
  logic [IDX_W-1:0]  next_ptr;
  logic              busy_timeout;
  logic              continue_pkt;
  logic              release_pkt;

  logic [DATA_W-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // busy_cnt counts completed WAIT_BUSY cycles; the last allowed one without
  // tx_busy ends the wait. tx_busy arriving in that same cycle still wins.
  assign busy_timeout = (state == WAIT_BUSY) && !tx_busy && (busy_cnt == TIMEOUT_LAST);

  // In WAIT_DONE tx_busy has already been seen high, so a low level is the
  // falling edge. The owner keeps the lock only if the byte just sent was not
  // the packet's last and it still presents a byte (dropping req aborts).
  assign continue_pkt = (state == WAIT_DONE) && !tx_busy && !last_q && req[grant_id];
  assign release_pkt  = (state == WAIT_DONE) && !tx_busy && !continue_pkt;

  assign next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_found) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)           state_nxt = WAIT_DONE;
        else if (busy_timeout) state_nxt = IDLE;
      end
      WAIT_DONE: begin
        if (continue_pkt)     state_nxt = ISSUE;
        else if (release_pkt) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // The handshake pulses exist only in ISSUE, and only toward the owner.
  always_comb begin
    tx_start = 1'b0;
    ack      = '0;
    if (state == ISSUE) begin
      tx_start      = 1'b1;
      ack[grant_id] = 1'b1;
    end
  end

  // Grant, byte latch, round-robin pointer and timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      tx_data     <= '0;
      last_q      <= 1'b0;
      busy_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= busy_timeout;
      busy_cnt    <= (state == WAIT_BUSY) ? busy_cnt + 8'd1 : 8'd0;

      if (state == IDLE && pick_found) begin
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
        tx_data     <= req_bytes[pick_idx];
        last_q      <= req_last[pick_idx];
      end

      if (continue_pkt) begin
        tx_data <= req_bytes[grant_id];
        last_q  <= req_last[grant_id];
      end

      // A timed-out byte was already acked, so it counts as the owner's turn.
      if (release_pkt || busy_timeout) begin
        grant_valid <= 1'b0;
        rr_ptr      <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// packet traffic compared against a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 20;
  localparam int IDX_W        = $clog2(NUM_REQ);
  localparam int MAXB         = 16;
  localparam int MAXE         = 64;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        ack;
  logic [IDX_W-1:0]          grant_id;
  logic                      grant_valid;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester byte queues and the expected transmit order.
  int q_data [NUM_REQ][MAXB];
  bit q_last [NUM_REQ][MAXB];
  int q_len  [NUM_REQ];
  int q_head [NUM_REQ];
  int exp_id   [MAXE];
  int exp_byte [MAXE];
  int exp_n;
  int abort_req, abort_cnt;
  int dly_min, dly_max, len_min, len_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    req_last = '0;
    tx_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic clear_queues();
    for (int r = 0; r < NUM_REQ; r++) begin
      q_len[r]  = 0;
      q_head[r] = 0;
    end
    exp_n     = 0;
    abort_req = -1;
    abort_cnt = 0;
  endtask

  task automatic push_byte(input int r, input int d, input bit l);
    q_data[r][q_len[r]] = d;
    q_last[r][q_len[r]] = l;
    q_len[r]++;
  endtask

  task automatic expect_byte(input int r, input int d);
    exp_id[exp_n]   = r;
    exp_byte[exp_n] = d;
    exp_n++;
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < NUM_REQ; r++) begin
      if (q_head[r] < q_len[r]) begin
        req[r]                       = 1'b1;
        req_data[r*DATA_W +: DATA_W] = DATA_W'(q_data[r][q_head[r]]);
        req_last[r]                  = q_last[r][q_head[r]];
      end else begin
        req[r]                       = 1'b0;
        req_data[r*DATA_W +: DATA_W] = '0;
        req_last[r]                  = 1'b0;
      end
    end
  endtask

  // Reference order when every requester keeps its queue presented:
  // whole packets served round-robin, starting from requester 0.
  task automatic build_expected();
    int h [NUM_REQ];
    int ptr, sel, r;
    bit l;
    for (int k = 0; k < NUM_REQ; k++) h[k] = 0;
    ptr = 0;
    while (1) begin
      sel = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        r = (ptr + k) % NUM_REQ;
        if (sel < 0 && h[r] < q_len[r]) sel = r;
      end
      if (sel < 0) break;
      l = 1'b0;
      while (!l) begin
        expect_byte(sel, q_data[sel][h[sel]]);
        l = q_last[sel][h[sel]];
        h[sel]++;
      end
      ptr = (sel + 1) % NUM_REQ;
    end
  endtask

  function automatic bit queues_empty();
    for (int r = 0; r < NUM_REQ; r++) if (q_head[r] < q_len[r]) return 1'b0;
    return 1'b1;
  endfunction

  // Cycle loop acting as requesters and as the transmitter (busy model).
  task automatic run_engine(input string name, input int budget);
    int got, phase, pcnt, settle, cur;
    bit err_seen;
    got = 0; phase = 0; pcnt = 0; settle = 0; cur = 0; err_seen = 1'b0;
    drive_reqs();
    for (int cyc = 0; cyc < budget && settle < 4; cyc++) begin
      step();
      if (err_timeout) err_seen = 1'b1;
      if (tx_start) begin
        if (got < exp_n) begin
          check({name, "_grant_id"}, 32'(grant_id), 32'(exp_id[got]));
          check({name, "_tx_data"}, 32'(tx_data), 32'(exp_byte[got]));
          check({name, "_ack"}, 32'(ack), 32'(1) << exp_id[got]);
          cur = exp_byte[got];
        end else begin
          check({name, "_start_count"}, 32'(got + 1), 32'(exp_n));
        end
        got++;
        for (int r = 0; r < NUM_REQ; r++) begin
          if (ack[r] && q_head[r] < q_len[r]) begin
            if (abort_req == r && q_head[r] == 0) abort_cnt = 3;
            q_head[r]++;
          end
        end
        phase = 1;
        pcnt  = $urandom_range(dly_max, dly_min);
      end
      if (phase == 1) begin
        if (pcnt == 0) begin
          tx_busy = 1'b1;
          phase   = 2;
          pcnt    = $urandom_range(len_max, len_min);
        end else pcnt--;
      end else if (phase == 2) begin
        if (pcnt == 0) begin
          check({name, "_tx_data_hold"}, 32'(tx_data), 32'(cur));
          tx_busy = 1'b0;
          phase   = 0;
        end else pcnt--;
      end
      if (abort_cnt > 0) begin
        abort_cnt--;
        if (abort_cnt == 0) q_head[abort_req] = q_len[abort_req];
      end
      drive_reqs();
      if (got >= exp_n && phase == 0 && queues_empty()) settle++;
    end
    check({name, "_finished"}, 32'(settle), 32'(4));
    check({name, "_byte_count"}, 32'(got), 32'(exp_n));
    check({name, "_no_timeout"}, 32'(err_seen), 32'(0));
    check({name, "_released"}, 32'(grant_valid), 32'(0));
  endtask

  initial begin
    int n;
    bit seen;

    // Reset state: outputs clear while reset is held.
    reset_n = 1'b0; req = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    #3;
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);

    // tx_busy pulse while idle is ignored.
    do_reset();
    tx_busy = 1'b1; step(); tx_busy = 1'b0; step();
    check("idle_busy_start", 32'(tx_start), 0);
    check("idle_busy_grant", 32'(grant_valid), 0);

    // Single requester 2, byte A5, 20-cycle frame.
    do_reset();
    req = 4'b0100; req_data[2*DATA_W +: DATA_W] = 8'hA5; req_last = 4'b0100;
    step();
    check("single_tx_start", 32'(tx_start), 1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    check("single_ack", 32'(ack), 32'b0100);
    check("single_grant_id", 32'(grant_id), 2);
    check("single_grant_valid", 32'(grant_valid), 1);
    req = '0; tx_busy = 1'b1;
    repeat (19) step();
    check("single_hold_data", 32'(tx_data), 32'hA5);
    check("single_hold_grant", 32'(grant_valid), 1);
    tx_busy = 1'b0;
    step();
    check("single_release", 32'(grant_valid), 0);
    // Pointer now sits at 3: with 0 and 3 pending, 3 wins.
    req = 4'b1001; req_last = 4'b1001;
    req_data[0 +: DATA_W] = 8'h01; req_data[3*DATA_W +: DATA_W] = 8'h03;
    step();
    check("rr_ptr_grant_id", 32'(grant_id), 3);
    check("rr_ptr_tx_data", 32'(tx_data), 32'h03);

    // All four requesters at once, single-byte packets.
    do_reset(); clear_queues();
    dly_min = 0; dly_max = 2; len_min = 2; len_max = 6;
    for (int r = 0; r < NUM_REQ; r++) push_byte(r, 'hA0 + r, 1'b1);
    for (int r = 0; r < NUM_REQ; r++) expect_byte(r, 'hA0 + r);
    run_engine("all4", 500);

    // Lock: 3-byte packet from req0 is not interleaved with req1.
    do_reset(); clear_queues();
    push_byte(0, 'h11, 1'b0); push_byte(0, 'h22, 1'b0); push_byte(0, 'h33, 1'b1);
    push_byte(1, 'h44, 1'b1);
    expect_byte(0, 'h11); expect_byte(0, 'h22); expect_byte(0, 'h33); expect_byte(1, 'h44);
    run_engine("lock", 500);

    // Abort: req0 drops req during byte 11; byte 22 never goes out.
    do_reset(); clear_queues();
    dly_min = 0; dly_max = 1; len_min = 8; len_max = 10;
    push_byte(0, 'h11, 1'b0); push_byte(0, 'h22, 1'b0); push_byte(0, 'h33, 1'b1);
    push_byte(1, 'h55, 1'b1);
    abort_req = 0;
    expect_byte(0, 'h11); expect_byte(1, 'h55);
    run_engine("abort", 500);

    // Timeout: tx_busy never rises.
    do_reset();
    req = 4'b1010; req_last = 4'b1010;
    req_data[1*DATA_W +: DATA_W] = 8'h61; req_data[3*DATA_W +: DATA_W] = 8'h63;
    step();
    check("to_first_grant", 32'(grant_id), 1);
    req[1] = 1'b0;
    n = 0; seen = 1'b0;
    for (int k = 0; k < BUSY_TIMEOUT + 10; k++) begin
      step();
      n++;
      if (err_timeout) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_seen", 32'(seen), 1);
    check("to_latency", 32'(n), 32'(BUSY_TIMEOUT + 1));
    check("to_release", 32'(grant_valid), 0);
    step();
    check("to_pulse_width", 32'(err_timeout), 0);
    check("to_rearb_start", 32'(tx_start), 1);
    check("to_rearb_grant", 32'(grant_id), 3);
    check("to_rearb_data", 32'(tx_data), 32'h63);

    // Reset during WAIT_DONE after the pointer has moved to 3.
    do_reset();
    req = 4'b0100; req_last = 4'b0100; req_data[2*DATA_W +: DATA_W] = 8'h72;
    step(); req = '0; tx_busy = 1'b1; step(); step(); tx_busy = 1'b0; step();
    req = 4'b0100; req_data[2*DATA_W +: DATA_W] = 8'h73;
    step();
    check("mid_second_grant", 32'(grant_id), 2);
    req = '0; tx_busy = 1'b1; step(); step();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_grant_valid", 32'(grant_valid), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_grant_id", 32'(grant_id), 0);
    tx_busy = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    req = 4'b1001; req_last = 4'b1001;
    req_data[0 +: DATA_W] = 8'h0A; req_data[3*DATA_W +: DATA_W] = 8'h3A;
    step();
    check("mid_after_grant", 32'(grant_id), 0);
    check("mid_after_data", 32'(tx_data), 32'h0A);

    // Randomized packet traffic against the round-robin model.
    for (int rnd = 0; rnd < 6; rnd++) begin
      int npk, plen;
      do_reset(); clear_queues();
      dly_min = 0; dly_max = 3; len_min = 1; len_max = 10;
      for (int r = 0; r < NUM_REQ; r++) begin
        npk = $urandom_range(2, 0);
        for (int p = 0; p < npk; p++) begin
          plen = $urandom_range(3, 1);
          for (int b = 0; b < plen; b++) push_byte(r, $urandom_range(255, 0), b == plen - 1);
        end
      end
      build_expected();
      run_engine("rand", 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
